fir_tdm_mac: RTL and testbench

- Parametrised successor to the fixed single-channel FIR.
- Time-division multi-channel FIR built around one shared multiply-accumulate unit.
- Coefficients are loaded at run time; input uses a valid/ready handshake; output is rounded and saturated.
- Sits between the sample source (ADC/peripheral FIFO) and the accelerator result bus.

---
 rtl/fir_tdm_mac.sv | 190 +++++++++++++++++++
 tb/tb_fir_tdm_mac.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tdm_mac.sv
// fir_tdm_mac: time-division multi-channel FIR filter built around one shared
// multiply-accumulate unit. Coefficients are loaded at run time and shared by
// all channels. Each channel has its own circular delay line. Samples enter
// through a valid/ready handshake. One filtered result leaves per accepted
// sample, NTAPS+1 enabled cycles after the accept.
//
// Ports:
//   i_clk        clock, all logic on the rising edge
//   i_reset      synchronous active-high reset (takes priority over i_ce)
//   i_ce         clock enable; low freezes every register
//   i_valid      sample present
//   o_ready      block can accept a sample (IDLE and not in reset)
//   i_sample     signed sample, IW bits
//   i_chan       channel of i_sample; values >= NCH are accepted and dropped
//   i_coef_we    coefficient write strobe (honoured only in IDLE)
//   i_coef_addr  tap index of the coefficient write
//   i_coef_data  signed coefficient, CW bits
//   o_valid      one-cycle result strobe
//   o_result     signed filtered output, OW bits; holds between strobes
//   o_chan       channel of o_result; holds between strobes
//
// Build option FIR_ROUND_SAT_EN:
//   defined   -> round half toward +inf, shift right by SHIFT, saturate to OW
//   undefined -> arithmetic shift right by SHIFT, keep the low OW bits (wrap)
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | ready for a sample; coefficient writes allowed
// S_MAC  | NTAPS cycles, one coefficient*sample product per cycle
// S_OUT  | o_valid high for one cycle, then back to S_IDLE

module fir_tdm_mac #(
    parameter int IW    = 12,
    parameter int CW    = 12,
    parameter int NTAPS = 16,
    parameter int NCH   = 2,
    parameter int OW    = 16,
    parameter int SHIFT = 10,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int TW   = $clog2(NTAPS)
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_ce,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [IW-1:0]  i_sample,
    input  logic [CHW-1:0] i_chan,
    input  logic           i_coef_we,
    input  logic [TW-1:0]  i_coef_addr,
    input  logic [CW-1:0]  i_coef_data,
    output logic           o_valid,
    output logic [OW-1:0]  o_result,
    output logic [CHW-1:0] o_chan
);

    localparam int AW = IW + CW + TW;
    localparam int PW = IW + CW;
    // Output-path working width: one guard bit above the accumulator so the
    // rounding add cannot overflow, and at least OW+1 bits wide.
    localparam int XW = (OW > AW) ? OW + 1 : AW + 1;
    localparam logic [CHW:0] NCH_V = (CHW + 1)'(NCH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t state, state_nxt;

    logic [IW-1:0]        dline [NCH][NTAPS];
    logic [TW-1:0]        wptr  [NCH];
    logic [CW-1:0]        coef  [NTAPS];
    logic signed [AW-1:0] acc, acc_nxt;
    logic signed [PW-1:0] prod;
    logic [TW-1:0]        tap, base, rd_idx;
    logic [CHW-1:0]       chan;
    logic                 chan_ok, take, coef_wr, last_tap;
    logic [OW-1:0]        res;

    assign chan_ok  = ({1'b0, i_chan} < NCH_V);
    assign take     = i_valid && o_ready && chan_ok;
    assign coef_wr  = i_coef_we && (state == S_IDLE);
    assign last_tap = (tap == TW'(NTAPS - 1));

    // base holds the slot of the newest sample; walking backwards from it
    // gives x[n-k], and the TW-bit subtraction wraps modulo NTAPS.
    assign rd_idx  = base - tap;
    assign prod    = PW'($signed(dline[chan][rd_idx])) * PW'($signed(coef[tap]));
    assign acc_nxt = acc + AW'(prod);

`ifdef FIR_ROUND_SAT_EN
    localparam logic signed [XW-1:0] RND    = XW'((64'sd1 <<< SHIFT) >>> 1);
    localparam logic signed [XW-1:0] SAT_HI = XW'((64'sd1 <<< (OW - 1)) - 64'sd1);
    localparam logic signed [XW-1:0] SAT_LO = XW'(-(64'sd1 <<< (OW - 1)));

    logic signed [XW-1:0] rnd_sum, shifted;

    always_comb begin
        rnd_sum = XW'(acc_nxt) + RND;
        shifted = rnd_sum >>> SHIFT;
        if (shifted > SAT_HI) begin
            res = OW'(SAT_HI);
        end else if (shifted < SAT_LO) begin
            res = OW'(SAT_LO);
        end else begin
            res = OW'(shifted);
        end
    end
`else
    always_comb begin
        res = OW'(XW'(acc_nxt) >>> SHIFT);
    end
`endif

    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        case (state)
            S_IDLE: begin
                o_ready = !i_reset;
                // An out-of-range channel completes the handshake but stays here.
                if (i_valid && chan_ok) begin
                    state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                if (last_tap) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= S_IDLE;
            acc      <= '0;
            tap      <= '0;
            base     <= '0;
            chan     <= '0;
            o_valid  <= 1'b0;
            o_result <= '0;
            o_chan   <= '0;
            for (int c = 0; c < NCH; c++) begin
                wptr[c] <= '0;
                for (int t = 0; t < NTAPS; t++) begin
                    dline[c][t] <= '0;
                end
            end
            for (int t = 0; t < NTAPS; t++) begin
                coef[t] <= '0;
            end
        end else if (i_ce) begin
            state <= state_nxt;
            // A write in the accept cycle lands before the first MAC read.
            if (coef_wr) begin
                coef[i_coef_addr] <= i_coef_data;
            end
            if (take) begin
                dline[i_chan][wptr[i_chan]] <= i_sample;
                wptr[i_chan] <= wptr[i_chan] + TW'(1);
                base         <= wptr[i_chan];
                chan         <= i_chan;
                tap          <= '0;
                acc          <= '0;
            end
            if (state == S_MAC) begin
                acc <= acc_nxt;
                tap <= tap + TW'(1);
                if (last_tap) begin
                    o_valid  <= 1'b1;
                    o_result <= res;
                    o_chan   <= chan;
                end
            end
            if (state == S_OUT) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_tdm_mac.sv
// Testbench for fir_tdm_mac. Three instances share one stimulus stream:
//   u_a: SHIFT=0, OW=28 (full accumulator visible)
//   u_b: SHIFT=0, OW=16 (saturation / wrap)
//   u_c: SHIFT=2, OW=16 (rounding / truncation)
// Directed samples carry hand-computed accumulator values; fmt() turns each
// into the expected output of every instance for the current build option.
// A monitor pops the scoreboard queues whenever an instance strobes o_valid.

module tb_fir_tdm_mac;

    localparam int IW    = 12;
    localparam int CW    = 12;
    localparam int NTAPS = 16;
    localparam int NCH   = 3;

    logic        clk = 1'b0;
    logic        rst, ce, valid, cwe;
    logic [11:0] sample, cdata;
    logic [1:0]  chan;
    logic [3:0]  caddr;

    logic        rdy_a, vld_a, rdy_b, vld_b, rdy_c, vld_c;
    logic [27:0] res_a;
    logic [15:0] res_b, res_c;
    logic [1:0]  ch_a, ch_b, ch_c;

    int checks = 0;
    int errors = 0;
    int ecyc   = 0;
    int rcyc   = 0;

    typedef struct {
        longint res;
        int     ch;
        int     ec;
    } exp_t;

    exp_t qa[$], qb[$], qc[$];
    exp_t ea, eb, ecx;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rcyc <= rcyc + 1;
        if (ce) ecyc <= ecyc + 1;
    end

    fir_tdm_mac #(.IW(IW), .CW(CW), .NTAPS(NTAPS), .NCH(NCH), .OW(28), .SHIFT(0)) u_a (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_valid(valid), .o_ready(rdy_a),
        .i_sample(sample), .i_chan(chan), .i_coef_we(cwe), .i_coef_addr(caddr),
        .i_coef_data(cdata), .o_valid(vld_a), .o_result(res_a), .o_chan(ch_a));

    fir_tdm_mac #(.IW(IW), .CW(CW), .NTAPS(NTAPS), .NCH(NCH), .OW(16), .SHIFT(0)) u_b (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_valid(valid), .o_ready(rdy_b),
        .i_sample(sample), .i_chan(chan), .i_coef_we(cwe), .i_coef_addr(caddr),
        .i_coef_data(cdata), .o_valid(vld_b), .o_result(res_b), .o_chan(ch_b));

    fir_tdm_mac #(.IW(IW), .CW(CW), .NTAPS(NTAPS), .NCH(NCH), .OW(16), .SHIFT(2)) u_c (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_valid(valid), .o_ready(rdy_c),
        .i_sample(sample), .i_chan(chan), .i_coef_we(cwe), .i_coef_addr(caddr),
        .i_coef_data(cdata), .o_valid(vld_c), .o_result(res_c), .o_chan(ch_c));

    function automatic longint fmt(longint acc, int sh, int ow);
        longint v;
`ifdef FIR_ROUND_SAT_EN
        longint hi, lo;
        v  = (sh > 0) ? acc + (longint'(1) <<< (sh - 1)) : acc;
        v  = v >>> sh;
        hi = (longint'(1) <<< (ow - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) v = hi;
        else if (v < lo) v = lo;
`else
        v = acc >>> sh;
        v = (v <<< (64 - ow)) >>> (64 - ow);
`endif
        return v;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=event expected=none", nm);
    endtask

    task automatic push_exp(input longint acc, input int ch, input int ec0);
        qa.push_back('{fmt(acc, 0, 28), ch, ec0});
        qb.push_back('{fmt(acc, 0, 16), ch, ec0});
        qc.push_back('{fmt(acc, 2, 16), ch, ec0});
    endtask

    // Monitor: latency counted in enabled cycles from the accept cycle.
    always @(posedge clk) begin
        #1;
        if (vld_a) begin
            if (qa.size() == 0) fail_now("a_unexpected_valid");
            else begin
                ea = qa.pop_front();
                chk("a_result", $signed(res_a), ea.res);
                chk("a_chan", ch_a, ea.ch);
                chk("a_latency", ecyc - ea.ec, NTAPS + 1);
            end
        end
        if (vld_b) begin
            if (qb.size() == 0) fail_now("b_unexpected_valid");
            else begin
                eb = qb.pop_front();
                chk("b_result", $signed(res_b), eb.res);
                chk("b_chan", ch_b, eb.ch);
            end
        end
        if (vld_c) begin
            if (qc.size() == 0) fail_now("c_unexpected_valid");
            else begin
                ecx = qc.pop_front();
                chk("c_result", $signed(res_c), ecx.res);
                chk("c_chan", ch_c, ecx.ch);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!rdy_a && n < 100) begin
            tick();
            n++;
        end
        if (!rdy_a) fail_now("wait_idle_timeout");
    endtask

    task automatic wr_coef(input int addr, input int data);
        wait_idle();
        cwe   = 1'b1;
        caddr = 4'(addr);
        cdata = 12'(data);
        tick();
        cwe = 1'b0;
    endtask

    task automatic send(input int ch, input int smp, input bit push, input longint acc_exp);
        int  ec0 = 0;
        bit  ok  = 1'b0;
        valid  = 1'b1;
        chan   = 2'(ch);
        sample = 12'(smp);
        for (int i = 0; i < 100 && !ok; i++) begin
            #1;
            if (rdy_a && ce) begin
                ok  = 1'b1;
                ec0 = ecyc;
            end
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        if (!ok) fail_now("send_timeout");
        else if (push) push_exp(acc_exp, ch, ec0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int  m, r0;
        bit  seen;
        rst = 1'b1; ce = 1'b1; valid = 1'b0; cwe = 1'b0;
        sample = '0; cdata = '0; chan = '0; caddr = '0;

        // Reset: ready low during reset, high right after, outputs cleared.
        tick();
        #1;
        chk("ready_in_reset", rdy_a, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", rdy_a, 1);
        chk("valid_after_reset", vld_a, 0);
        chk("result_after_reset", res_a, 0);
        chk("chan_after_reset", ch_a, 0);

        // Impulse on ch0 interleaved with a constant 100 on ch1.
        for (int k = 0; k < NTAPS; k++) wr_coef(k, k + 1);
        for (int j = 1; j <= 17; j++) begin
            send(0, (j == 1) ? 1 : 0, 1, (j <= 16) ? j : 0);
            m = (j < 16) ? j : 16;
            send(1, 100, 1, 100 * m * (m + 1) / 2);
        end

        // Saturation: 2047*2047 per tap, 67043344 after 16 samples.
        for (int k = 0; k < NTAPS; k++) wr_coef(k, 2047);
        for (int j = 1; j <= 16; j++) send(0, 2047, 1, longint'(j) * 4190209);

        // Rounding on fresh ch2 with coef = {1, 0, ...}.
        for (int k = 0; k < NTAPS; k++) wr_coef(k, (k == 0) ? 1 : 0);
        send(2, 6, 1, 6);
        send(2, -6, 1, -6);
        send(2, 5, 1, 5);
        send(2, -2, 1, -2);

        // Coefficient write in the accept cycle is used by that sample.
        wait_idle();
        cwe = 1'b1; caddr = 4'd0; cdata = 12'd5;
        send(2, 3, 1, 15);
        cwe = 1'b0;

        // Handshake: i_valid held, i_ce low 3 cycles in MAC, write pulsed in MAC.
        wait_idle();
        valid = 1'b1; chan = 2'd1; sample = 12'd7;
        #1;
        chk("ready_idle", rdy_a, 1);
        push_exp(35, 1, ecyc);
        r0 = rcyc;
        tick();
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            if (i == 2) ce = 1'b0;
            if (i == 5) ce = 1'b1;
            cwe = (i == 7); caddr = 4'd0; cdata = 12'd500;
            #1;
            if (vld_a) begin
                seen = 1'b1;
                chk("stall_latency", rcyc - r0, NTAPS + 1 + 3);
                chk("ready_in_out", rdy_a, 0);
                valid = 1'b0;
            end else begin
                chk("ready_in_mac", rdy_a, 0);
                tick();
            end
        end
        cwe = 1'b0; ce = 1'b1; valid = 1'b0;
        if (!seen) fail_now("stall_valid_timeout");
        send(1, 1, 1, 5);

        // Coefficient write with i_ce low is ignored.
        wait_idle();
        ce = 1'b0; cwe = 1'b1; caddr = 4'd0; cdata = 12'd77;
        tick();
        cwe = 1'b0; ce = 1'b1;
        send(1, 2, 1, 10);

        // Out-of-range channel: accepted, dropped, block stays ready.
        wait_idle();
        send(3, 99, 0, 0);
        #1;
        chk("ready_after_bad_chan", rdy_a, 1);
        send(2, 4, 1, 20);

        // Reset during tap 5 aborts the computation and clears everything.
        wait_idle();
        send(0, 50, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #1;
        chk("ready_in_mid_reset", rdy_a, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("ready_after_mid_reset", rdy_a, 1);
        chk("valid_after_mid_reset", vld_a, 0);
        chk("result_after_mid_reset", res_a, 0);
        chk("chan_after_mid_reset", ch_a, 0);
        for (int k = 0; k < NTAPS; k++) wr_coef(k, k + 1);
        send(0, 1, 1, 1);

        for (int i = 0; i < 60 && (qa.size() + qb.size() + qc.size()) > 0; i++) tick();
        for (int i = 0; i < 5; i++) tick();
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        chk("c_queue_empty", qc.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
